// File: rtl/strip_pkg.sv
// Shared types for the strip scan controller: FSM state encoding and the
// address-width helper used to size column addresses.
package strip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FETCH,
    ST_WAIT,
    ST_OUT
  } strip_state_t;

  // Column address width; never collapses to zero for a one-column image.
  function automatic int strip_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strip_col_detect.sv
// Column occupancy detector: OR-reduces the returned column word and flags
// a hit only while the controller is still searching, so the first occupied
// column is the only one reported.
module strip_col_detect #(
  parameter int IMG_H = 200
) (
  input  logic [IMG_H-1:0] col_data,
  input  logic             col_vld,
  input  logic             armed,
  output logic             hit
);

  // Any set pixel in a valid word during the search is a hit.
  always_comb begin
    hit = armed & col_vld & (|col_data);
  end

endmodule

// File: rtl/strip_scan_ctrl.sv
// Test-strip extraction controller. Streams column reads left to right,
// stops at the first occupied column c, reads column min(c+STRIP_OFFSET,
// IMG_W-1) and presents it on a valid/ready result port.
// Optional build macro: STRIP_SCAN_CYCLES_EN adds the scan_cycles output.
module strip_scan_ctrl
  import strip_pkg::*;
#(
  parameter int IMG_W        = 200,
  parameter int IMG_H        = 200,
  parameter int STRIP_OFFSET = 30
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       col_rd_en,
  output logic [$clog2(IMG_W)-1:0]   col_addr,
  input  logic [IMG_H-1:0]           col_data,
  output logic                       strip_valid,
  input  logic                       strip_ready,
  output logic [IMG_H-1:0]           strip_data,
  output logic [$clog2(IMG_W)-1:0]   strip_col,
  output logic                       strip_found
`ifdef STRIP_SCAN_CYCLES_EN
  ,
  output logic [$clog2(IMG_W+4):0]   scan_cycles
`endif
);

  localparam int AW = strip_aw(IMG_W);

  // Arithmetic is one bit wider than the address so the counter can reach
  // IMG_W and the offset sum cannot wrap before the clamp.
  localparam logic [AW:0] ONE_C  = (AW+1)'(1);
  localparam logic [AW:0] W_C    = (AW+1)'(IMG_W);
  localparam logic [AW:0] LAST_C = (AW+1)'(IMG_W-1);
  localparam logic [AW:0] OFF_C  = (AW+1)'(STRIP_OFFSET);

  strip_state_t state;

  logic [AW:0]   scan_cnt;   // index k of the current SCAN cycle
  logic [AW:0]   scan_nxt;
  logic [AW:0]   hit_col;    // column whose word is on col_data now
  logic [AW:0]   tgt_sum;
  logic [AW-1:0] tgt;
  // vld_pipe[0]: read issued this cycle, vld_pipe[1]: its data is on col_data
  logic [1:0]    vld_pipe;
  logic          hit;

  assign col_rd_en = vld_pipe[0];

  // Next scan index, current data column and clamped strip target.
  always_comb begin
    scan_nxt = scan_cnt + ONE_C;
    hit_col  = scan_cnt - ONE_C;
    tgt_sum  = hit_col + OFF_C;
    tgt      = (tgt_sum > LAST_C) ? LAST_C[AW-1:0] : tgt_sum[AW-1:0];
  end

  strip_col_detect #(
    .IMG_H (IMG_H)
  ) u_detect (
    .col_data (col_data),
    .col_vld  (vld_pipe[1]),
    .armed    (state == ST_SCAN),
    .hit      (hit)
  );

  // Control FSM, read pipeline and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      vld_pipe    <= 2'b00;
      col_addr    <= '0;
      scan_cnt    <= '0;
      strip_valid <= 1'b0;
      strip_found <= 1'b0;
      strip_data  <= '0;
      strip_col   <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      case (state)
        ST_IDLE: begin
          scan_cnt <= '0;
          if (start) begin
            state       <= ST_SCAN;
            busy        <= 1'b1;
            vld_pipe[0] <= 1'b1;
            col_addr    <= '0;
          end
        end
        ST_SCAN: begin
          if (hit) begin
            // Reads still in flight past the hit are simply never looked at.
            state       <= ST_FETCH;
            vld_pipe[0] <= 1'b1;
            col_addr    <= tgt;
          end else if (vld_pipe[1] && (scan_cnt == W_C)) begin
            // Last column came back empty: report an empty image.
            state       <= ST_OUT;
            vld_pipe[0] <= 1'b0;
            strip_valid <= 1'b1;
            strip_found <= 1'b0;
            strip_data  <= '0;
            strip_col   <= '0;
          end else begin
            scan_cnt    <= scan_nxt;
            vld_pipe[0] <= (scan_nxt < W_C);
            if (scan_nxt < W_C) col_addr <= scan_nxt[AW-1:0];
          end
        end
        ST_FETCH: begin
          vld_pipe[0] <= 1'b0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          strip_data  <= col_data;
          strip_col   <= col_addr;
          strip_found <= 1'b1;
          strip_valid <= 1'b1;
          state       <= ST_OUT;
        end
        ST_OUT: begin
          if (strip_ready) begin
            strip_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STRIP_SCAN_CYCLES_EN
  localparam int CW = $clog2(IMG_W+4) + 1;

  // Counts working cycles of a request; frozen while the result waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      scan_cycles <= '0;
    else if (state == ST_IDLE && start)
      scan_cycles <= '0;
    else if (busy && state != ST_OUT)
      scan_cycles <= scan_cycles + CW'(1);
  end
`endif

endmodule
